turn_sequencer: RTL

//  Parametrised player-turn sequencer for the game controller. It generalises the

---
 rtl/turn_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
// Player-turn sequencer for the game controller. Tracks whose turn it is among
// up to MAX_PLAYERS seats. It skips eliminated seats and can reverse the play
// direction. It forces a turn change after a per-turn timeout, counts completed
// rounds, and stops with the winner shown once at most one seat is left.
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   start_i          one-cycle pulse, (re)starts the game; highest priority
//   last_player_i    highest seat index in play, latched on start (0 -> 1)
//   advance_i        level from the game FSM; each rising edge ends the turn
//   reverse_i        one-cycle pulse, toggles play direction while running
//   out_mask_i       bit i set: seat i eliminated
//   timeout_limit_i  cycles allowed per turn, 0 disables the timeout
//   cur_player_o     seat whose turn it is
//   running_o        game in progress
//   game_over_o      game halted, cur_player_o shows the winner
//   round_cnt_o      completed rounds since start, saturating
//   new_round_o      one-cycle pulse when a turn change wraps around
//   turn_timeout_o   one-cycle pulse when the timeout forced the turn change
// ---------------------------------------------------------------------------
module turn_sequencer #(
    parameter int unsigned MAX_PLAYERS = 4,
    parameter int unsigned PLAYER_W    = 2,
    parameter int unsigned ROUND_W     = 8,
    parameter int unsigned TO_W        = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [PLAYER_W-1:0]    last_player_i,
    input  logic                   advance_i,
    input  logic                   reverse_i,
    input  logic [MAX_PLAYERS-1:0] out_mask_i,
    input  logic [TO_W-1:0]        timeout_limit_i,
    output logic [PLAYER_W-1:0]    cur_player_o,
    output logic                   running_o,
    output logic                   game_over_o,
    output logic [ROUND_W-1:0]     round_cnt_o,
    output logic                   new_round_o,
    output logic                   turn_timeout_o
);

    // One extra bit so a seat count of MAX_PLAYERS and cur+step sums fit
    localparam int unsigned CNT_W = PLAYER_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t                  state_q;
    logic [PLAYER_W-1:0]     cur_q;
    logic [PLAYER_W-1:0]     last_q;
    logic                    dir_q;        // 0 = forward, 1 = reverse
    logic [ROUND_W-1:0]      round_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic                    adv_q;
    logic                    running_q;
    logic                    game_over_q;
    logic                    new_round_q;
    logic                    turn_to_q;

    logic [PLAYER_W-1:0]     last_eff;
    logic [MAX_PLAYERS-1:0]  elig_run;
    logic [MAX_PLAYERS-1:0]  elig_start;
    logic [CNT_W-1:0]        n_run;
    logic [CNT_W-1:0]        n_start;
    logic [PLAYER_W-1:0]     low_run;
    logic [PLAYER_W-1:0]     low_start;
    logic                    dir_d;
    logic [CNT_W-1:0]        n_seats;
    logic [CNT_W-1:0]        idx;
    logic [PLAYER_W-1:0]     next_player_d;
    logic                    found;
    logic                    wrap;
    logic                    adv_rise;
    logic                    to_hit;
    logic                    trigger;

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_PLAYERS-1:0] v);
        popcount = '0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            popcount = popcount + CNT_W'(v[i]);
        end
    endfunction

    // Lowest set index, 0 when the vector is empty
    function automatic logic [PLAYER_W-1:0] lowest(input logic [MAX_PLAYERS-1:0] v);
        lowest = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest = PLAYER_W'(i);
            end
        end
    endfunction

    assign last_eff = (last_player_i == '0) ? PLAYER_W'(1) : last_player_i;

    // Eligible seats against the latched seat count and the one being started
    always_comb begin
        elig_run   = '0;
        elig_start = '0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            elig_run[i]   = ~out_mask_i[i] && (PLAYER_W'(i) <= last_q);
            elig_start[i] = ~out_mask_i[i] && (PLAYER_W'(i) <= last_eff);
        end
    end

    assign n_run     = popcount(elig_run);
    assign n_start   = popcount(elig_start);
    assign low_run   = lowest(elig_run);
    assign low_start = lowest(elig_start);

    assign dir_d    = dir_q ^ reverse_i;
    assign adv_rise = advance_i & ~adv_q;
    assign to_hit   = (timeout_limit_i != '0) && (to_cnt_q == timeout_limit_i - TO_W'(1));
    assign trigger  = adv_rise | to_hit;

    // Step from the current seat in the effective direction, modulo the seat
    // count, to the first eligible seat. idx stays below 2*n_seats, so one
    // conditional subtraction gives the modulo.
    always_comb begin
        n_seats       = CNT_W'(last_q) + CNT_W'(1);
        next_player_d = cur_q;
        found         = 1'b0;
        idx           = '0;
        for (int k = 1; k <= MAX_PLAYERS; k++) begin
            if (dir_d) begin
                idx = CNT_W'(cur_q) + n_seats - CNT_W'(k);
            end else begin
                idx = CNT_W'(cur_q) + CNT_W'(k);
            end
            if (idx >= n_seats) begin
                idx = idx - n_seats;
            end
            if (!found && (CNT_W'(k) <= n_seats) && elig_run[idx[PLAYER_W-1:0]]) begin
                next_player_d = idx[PLAYER_W-1:0];
                found         = 1'b1;
            end
        end
    end

    assign wrap = dir_d ? (next_player_d >= cur_q) : (next_player_d <= cur_q);

    // Game FSM with all outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            dir_q       <= 1'b0;
            round_q     <= '0;
            to_cnt_q    <= '0;
            adv_q       <= 1'b0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            new_round_q <= 1'b0;
            turn_to_q   <= 1'b0;
        end else begin
            adv_q       <= advance_i;
            new_round_q <= 1'b0;
            turn_to_q   <= 1'b0;
            if (start_i) begin
                last_q   <= last_eff;
                cur_q    <= low_start;
                dir_q    <= 1'b0;
                round_q  <= '0;
                to_cnt_q <= '0;
                if (n_start <= CNT_W'(1)) begin
                    state_q     <= S_HALT;
                    running_q   <= 1'b0;
                    game_over_q <= 1'b1;
                end else begin
                    state_q     <= S_RUN;
                    running_q   <= 1'b1;
                    game_over_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (n_run <= CNT_W'(1)) begin
                            // Winner is the sole survivor; keep the seat if none remain
                            state_q     <= S_HALT;
                            running_q   <= 1'b0;
                            game_over_q <= 1'b1;
                            if (n_run == CNT_W'(1)) begin
                                cur_q <= low_run;
                            end
                        end else begin
                            dir_q <= dir_d;
                            if (trigger) begin
                                cur_q     <= next_player_d;
                                to_cnt_q  <= '0;
                                turn_to_q <= to_hit & ~adv_rise;
                                if (wrap) begin
                                    new_round_q <= 1'b1;
                                    if (round_q != '1) begin
                                        round_q <= round_q + ROUND_W'(1);
                                    end
                                end
                            end else begin
                                to_cnt_q <= to_cnt_q + TO_W'(1);
                            end
                        end
                    end
                    default: begin
                        // IDLE and HALT wait for start
                    end
                endcase
            end
        end
    end

    assign cur_player_o   = cur_q;
    assign running_o      = running_q;
    assign game_over_o    = game_over_q;
    assign round_cnt_o    = round_q;
    assign new_round_o    = new_round_q;
    assign turn_timeout_o = turn_to_q;

endmodule
